// File: rtl/jt12_wrq_if.sv
// Host-write and register-block signal bundle for the JT12 write queue.
interface jt12_wrq_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          clk_en;
  logic          wr_req;
  logic          wr_part;
  logic [7:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          wr_ack;
  logic [LW-1:0] level;
  logic          busy;
  logic [7:0]    din;
  logic [2:0]    ch;
  logic [1:0]    op;
  logic [11:0]   up;
  logic          drop;
  logic          err;

  modport master (
    output clk_en, wr_req, wr_part, wr_addr, wr_data, busy,
    input  wr_ack, level, din, ch, op, up, drop, err
  );

  modport slave (
    input  clk_en, wr_req, wr_part, wr_addr, wr_data, busy,
    output wr_ack, level, din, ch, op, up, drop, err
  );
endinterface

// File: rtl/jt12_wrq.sv
// Host register-write queue for the JT12 register block: FIFOs writes and replays each
// as an up-strobe held against busy, advancing only on clk_en; unmapped addresses are dropped.
module jt12_wrq #(
  parameter int DEPTH = 4,
  parameter int TMO   = 32
) (
  input  logic      clk,
  input  logic      rst,
  jt12_wrq_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TMO + 1);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  localparam int UP_KEYON  = 0;
  localparam int UP_ALG    = 1;
  localparam int UP_BLOCK  = 2;
  localparam int UP_FNUMLO = 3;
  localparam int UP_PMS    = 4;
  localparam int UP_DT1    = 5;
  localparam int UP_TL     = 6;
  localparam int UP_KSAR   = 7;
  localparam int UP_AMD1R  = 8;
  localparam int UP_D2R    = 9;
  localparam int UP_D1L    = 10;
  localparam int UP_SSGEG  = 11;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, HOLD = 2'd2, GAP = 2'd3} state_t;

  typedef struct packed {
    logic       part;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_ent_t;

  state_t        state_q, state_d;
  wr_ent_t       mem_q [DEPTH];
  wr_ent_t       head;
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   level_q, level_d;
  logic          push, pop;

  logic          dec_vld;
  logic [11:0]   dec_up;
  logic [2:0]    dec_ch;
  logic [1:0]    dec_op;

  logic [7:0]    din_q;
  logic [2:0]    ch_q;
  logic [1:0]    op_q;
  logic [11:0]   sel_q;
  logic [TW-1:0] tmo_q;
  logic          tmo_hit;
  logic          err_q;
  logic          drop_q;

  // Full is judged on the registered level, so a same-cycle pop never frees a slot.
  assign push = bus.wr_req & ~rst & (level_q < FULL_LVL);
  assign pop  = bus.clk_en & (state_q == IDLE) & (level_q != '0);
  assign head = mem_q[rp_q];

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + (AW+1)'(1);
    else if (!push && pop) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {bus.wr_part, bus.wr_addr, bus.wr_data};
  end

  always_comb begin
    dec_vld = 1'b0;
    dec_up  = '0;
    dec_op  = '0;
    dec_ch  = {head.part, head.addr[1:0]};
    if (head.addr == 8'h28) begin
      dec_vld          = 1'b1;
      dec_ch           = '0;
      dec_up[UP_KEYON] = 1'b1;
    end else if (head.addr[1:0] != 2'd3) begin
      dec_vld = 1'b1;
      case (head.addr[7:4])
        4'h3: dec_up[UP_DT1]   = 1'b1;
        4'h4: dec_up[UP_TL]    = 1'b1;
        4'h5: dec_up[UP_KSAR]  = 1'b1;
        4'h6: dec_up[UP_AMD1R] = 1'b1;
        4'h7: dec_up[UP_D2R]   = 1'b1;
        4'h8: dec_up[UP_D1L]   = 1'b1;
        4'h9: dec_up[UP_SSGEG] = 1'b1;
        4'hA: begin
          if (head.addr[3:2] == 2'd0)      dec_up[UP_FNUMLO] = 1'b1;
          else if (head.addr[3:2] == 2'd1) dec_up[UP_BLOCK]  = 1'b1;
          else                             dec_vld = 1'b0;
        end
        4'hB: begin
          if (head.addr[3:2] == 2'd0)      dec_up[UP_ALG] = 1'b1;
          else if (head.addr[3:2] == 2'd1) dec_up[UP_PMS] = 1'b1;
          else                             dec_vld = 1'b0;
        end
        default: dec_vld = 1'b0;
      endcase
      // Only the per-operator range carries an operator slot in addr[3:2].
      if (head.addr < 8'hA0) dec_op = head.addr[3:2];
    end
  end

  assign tmo_hit = (state_q == ISSUE) & bus.clk_en & ~bus.busy & (tmo_q == TW'(TMO - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.clk_en) begin
      case (state_q)
        IDLE:    if (pop && dec_vld) state_d = ISSUE;
        ISSUE:   if (bus.busy) state_d = HOLD;
                 else if (tmo_hit) state_d = GAP;
        HOLD:    if (!bus.busy) state_d = GAP;
        GAP:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.up = '0;
    if (state_q == ISSUE || state_q == HOLD) bus.up = sel_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_q  <= '0;
      ch_q   <= '0;
      op_q   <= '0;
      sel_q  <= '0;
      tmo_q  <= '0;
      err_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= pop & ~dec_vld;
      if (pop && dec_vld) begin
        din_q <= head.data;
        ch_q  <= dec_ch;
        op_q  <= dec_op;
        sel_q <= dec_up;
      end
      if (bus.clk_en) tmo_q <= (state_q == ISSUE && state_d == ISSUE) ? tmo_q + TW'(1) : '0;
      if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign bus.wr_ack = push;
  assign bus.level  = level_q;
  assign bus.din    = din_q;
  assign bus.ch     = ch_q;
  assign bus.op     = op_q;
  assign bus.drop   = drop_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_jt12_wrq.sv
// Scoreboard bench for jt12_wrq: expected strobes/drops queued at accept time, checked as they appear.
module tb_jt12_wrq;
  localparam int DEPTH = 4;
  localparam int TMO   = 32;

  localparam int UP_KEYON = 0, UP_ALG = 1, UP_BLOCK = 2, UP_FNUMLO = 3, UP_PMS = 4, UP_DT1 = 5;
  localparam int UP_TL = 6, UP_KSAR = 7, UP_AMD1R = 8, UP_D2R = 9, UP_D1L = 10, UP_SSGEG = 11;

  typedef struct {
    logic        is_drop;
    logic [11:0] up;
    logic [2:0]  ch;
    logic [1:0]  op;
    logic [7:0]  din;
    int          len;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jt12_wrq_if #(.DEPTH(DEPTH)) bus ();
  jt12_wrq #(.DEPTH(DEPTH), .TMO(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   busy_mode = 0;  // 0: low, 1: pulse of busy_len clks per strobe, 2: held high
  int   busy_len  = 24;
  logic en_div    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t iss(input int b, input logic [2:0] c, input logic [1:0] o,
                               input logic [7:0] d, input int len);
    exp_t e;
    e.is_drop = 1'b0; e.up = '0; e.up[b] = 1'b1;
    e.ch = c; e.op = o; e.din = d; e.len = len;
    return e;
  endfunction

  function automatic exp_t drp();
    exp_t e;
    e.is_drop = 1'b1; e.up = '0; e.ch = '0; e.op = '0; e.din = '0; e.len = 0;
    return e;
  endfunction

  // clk_en generator: always on, or one clk in three
  int en_ph = 0;
  always @(negedge clk) begin
    en_ph = (en_ph == 2) ? 0 : en_ph + 1;
    bus.clk_en = en_div ? (en_ph == 0) : 1'b1;
  end

  // busy responder modelling the register block
  logic [11:0] rsp_prev_up = '0;
  int          busy_cnt = 0;
  always @(negedge clk) begin
    if (busy_mode == 2) bus.busy = 1'b1;
    else if (busy_mode == 0) begin
      bus.busy = 1'b0;
      busy_cnt = 0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) bus.busy = 1'b0;
    end else if (bus.up != 0 && rsp_prev_up == 0) begin
      bus.busy = 1'b1;
      busy_cnt = busy_len;
    end else bus.busy = 1'b0;
    rsp_prev_up = bus.up;
  end

  // output monitor
  logic        en_last = 1'b0;
  logic [11:0] mon_prev_up = '0;
  logic        act = 1'b0;
  int          up_len = 0;
  exp_t        cur, mon_e;

  always @(posedge clk) en_last = bus.clk_en;

  always @(negedge clk) begin
    if (rst) begin
      mon_prev_up = '0;
      act = 1'b0;
    end else begin
      if (bus.drop) begin
        chk("drop_on_en", en_last, 1);
        if (sb_q.size() == 0) chk("drop_unexpected", bus.drop, 0);
        else begin
          mon_e = sb_q.pop_front();
          chk("drop_kind", mon_e.is_drop, 1);
        end
      end
      if (bus.up != 0 && mon_prev_up == 0) begin
        chk("rise_on_en", en_last, 1);
        if (sb_q.size() == 0) chk("up_unexpected", bus.up, 0);
        else begin
          cur = sb_q.pop_front();
          act = 1'b1;
          up_len = 0;
          chk("kind", cur.is_drop, 0);
          chk("up", bus.up, cur.up);
          chk("ch", bus.ch, cur.ch);
          chk("op", bus.op, cur.op);
          chk("din", bus.din, cur.din);
        end
      end else if (bus.up != 0 && act) begin
        chk("up_hold", bus.up, cur.up);
        chk("din_hold", bus.din, cur.din);
      end
      if (bus.up != 0) up_len++;
      if (bus.up == 0 && mon_prev_up != 0 && act) begin
        chk("fall_on_en", en_last, 1);
        chk("gap_din", bus.din, cur.din);
        chk("gap_ch", bus.ch, cur.ch);
        chk("gap_op", bus.op, cur.op);
        if (cur.len != 0) chk("up_len", up_len, cur.len);
        act = 1'b0;
      end
      mon_prev_up = bus.up;
    end
  end

  task automatic host_write(input logic p, input logic [7:0] a, input logic [7:0] d,
                            input exp_t e, output logic ok);
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_part = p; bus.wr_addr = a; bus.wr_data = d;
    #1 ok = bus.wr_ack;
    if (ok) sb_q.push_back(e);
    @(posedge clk);
    #1 bus.wr_req = 1'b0;
  endtask

  task automatic host_put(input logic p, input logic [7:0] a, input logic [7:0] d, input exp_t e);
    logic ok;
    int   n = 0;
    do begin
      host_write(p, a, d, e, ok);
      n++;
    end while (!ok && n < 400);
    if (!ok) chk("put_tmo", n, 0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || act || bus.level != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("drain_tmo", n, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_act(input int budget);
    int n = 0;
    while (!act && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("wait_act_tmo", n, 0);
  endtask

  logic [4:0] acks;
  logic       ok_m;

  initial begin
    rst = 1'b1;
    bus.wr_req = 1'b0; bus.wr_part = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    repeat (3) @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_addr = 8'h40;
    #1 chk("ack_in_rst", bus.wr_ack, 0);
    @(negedge clk);
    bus.wr_req = 1'b0;
    chk("rst_level", bus.level, 0);
    chk("rst_up", bus.up, 0);
    chk("rst_din", bus.din, 0);
    chk("rst_ch", bus.ch, 0);
    chk("rst_op", bus.op, 0);
    chk("rst_drop", bus.drop, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b0;

    // single tl write, busy rises next clk_en and falls 24 later
    busy_mode = 1; busy_len = 24;
    host_write(1'b0, 8'h40, 8'h7F, iss(UP_TL, 3'd0, 2'd0, 8'h7F, 25), ok_m);
    chk("ack_first", ok_m, 1);
    chk("level_after_push", bus.level, 1);
    drain(200);

    // decode sweep including drops
    busy_len = 4;
    host_put(1'b1, 8'hA5, 8'h22, iss(UP_BLOCK, 3'd5, 2'd0, 8'h22, 5));
    host_put(1'b0, 8'h33, 8'h11, drp());
    host_put(1'b0, 8'h28, 8'hF1, iss(UP_KEYON, 3'd0, 2'd0, 8'hF1, 5));
    host_put(1'b1, 8'h28, 8'h06, iss(UP_KEYON, 3'd0, 2'd0, 8'h06, 5));
    host_put(1'b1, 8'h9E, 8'h0A, iss(UP_SSGEG, 3'd6, 2'd3, 8'h0A, 5));
    host_put(1'b0, 8'h5D, 8'h1F, iss(UP_KSAR, 3'd1, 2'd3, 8'h1F, 5));
    host_put(1'b0, 8'hA3, 8'h00, drp());
    host_put(1'b1, 8'hB4, 8'hC0, iss(UP_PMS, 3'd4, 2'd0, 8'hC0, 5));
    host_put(1'b0, 8'hA1, 8'h9A, iss(UP_FNUMLO, 3'd1, 2'd0, 8'h9A, 5));
    host_put(1'b0, 8'hB2, 8'h3B, iss(UP_ALG, 3'd2, 2'd0, 8'h3B, 5));
    host_put(1'b0, 8'h2C, 8'h00, drp());
    host_put(1'b0, 8'h7C, 8'h44, iss(UP_D2R, 3'd0, 2'd3, 8'h44, 5));
    host_put(1'b1, 8'h61, 8'h85, iss(UP_AMD1R, 3'd5, 2'd0, 8'h85, 5));
    host_put(1'b0, 8'h86, 8'hE3, iss(UP_D1L, 3'd2, 2'd1, 8'hE3, 5));
    host_put(1'b1, 8'h36, 8'h71, iss(UP_DT1, 3'd6, 2'd1, 8'h71, 5));
    host_put(1'b0, 8'hA8, 8'h00, drp());
    host_put(1'b0, 8'h30, 8'h12, iss(UP_DT1, 3'd0, 2'd0, 8'h12, 5));
    host_put(1'b0, 8'h9C, 8'h0F, iss(UP_SSGEG, 3'd0, 2'd3, 8'h0F, 5));
    host_put(1'b0, 8'hB8, 8'h00, drp());
    host_put(1'b1, 8'hA0, 8'h5C, iss(UP_FNUMLO, 3'd4, 2'd0, 8'h5C, 5));
    host_put(1'b0, 8'hC0, 8'h00, drp());
    host_put(1'b0, 8'h2F, 8'h00, drp());
    drain(600);
    chk("level_drained", bus.level, 0);

    // FIFO full while the head is stalled in HOLD
    busy_mode = 2;
    host_put(1'b0, 8'h42, 8'h55, iss(UP_TL, 3'd2, 2'd0, 8'h55, 0));
    wait_act(100);
    repeat (2) @(negedge clk);
    host_write(1'b0, 8'h44, 8'h01, iss(UP_TL, 3'd0, 2'd1, 8'h01, 3), acks[0]);
    host_write(1'b1, 8'h28, 8'h02, iss(UP_KEYON, 3'd0, 2'd0, 8'h02, 3), acks[1]);
    host_write(1'b1, 8'hA2, 8'h03, iss(UP_FNUMLO, 3'd6, 2'd0, 8'h03, 3), acks[2]);
    host_write(1'b0, 8'h50, 8'h04, iss(UP_KSAR, 3'd0, 2'd0, 8'h04, 3), acks[3]);
    host_write(1'b0, 8'hB0, 8'h05, iss(UP_ALG, 3'd0, 2'd0, 8'h05, 3), acks[4]);
    chk("full_acks", acks, 5'b01111);
    chk("full_level", bus.level, 4);
    busy_mode = 1; busy_len = 2;
    drain(300);

    // timeout abort with busy never rising
    chk("err_before_tmo", bus.err, 0);
    busy_mode = 0;
    host_put(1'b0, 8'h41, 8'h01, iss(UP_TL, 3'd1, 2'd0, 8'h01, TMO));
    host_put(1'b0, 8'hB1, 8'h02, iss(UP_ALG, 3'd1, 2'd0, 8'h02, TMO));
    drain(300);
    chk("err_after_tmo", bus.err, 1);

    // sparse clk_en
    en_div = 1'b1; busy_mode = 1; busy_len = 12;
    host_put(1'b0, 8'h4A, 8'hA5, iss(UP_TL, 3'd2, 2'd2, 8'hA5, 0));
    host_put(1'b0, 8'h33, 8'h00, drp());
    host_put(1'b1, 8'h28, 8'h5A, iss(UP_KEYON, 3'd0, 2'd0, 8'h5A, 0));
    drain(800);
    chk("err_sticky", bus.err, 1);

    // reset while a write is held and others are queued
    busy_mode = 2;
    host_put(1'b1, 8'h40, 8'h11, iss(UP_TL, 3'd4, 2'd0, 8'h11, 0));
    wait_act(100);
    host_put(1'b0, 8'h45, 8'h22, iss(UP_TL, 3'd1, 2'd1, 8'h22, 0));
    host_put(1'b0, 8'h46, 8'h33, iss(UP_TL, 3'd2, 2'd1, 8'h33, 0));
    chk("pre_rst_up", bus.up, 12'h040);
    @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    chk("rst_hold_up", bus.up, 0);
    chk("rst_hold_level", bus.level, 0);
    chk("rst_hold_err", bus.err, 0);
    chk("rst_hold_din", bus.din, 0);
    @(negedge clk);
    rst = 1'b0;
    en_div = 1'b0; busy_mode = 1; busy_len = 3;
    host_put(1'b1, 8'hB5, 8'h77, iss(UP_PMS, 3'd5, 2'd0, 8'h77, 4));
    drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1);
  end
endmodule
